// File: rtl/round_scheduler.sv
// Round scheduler for the matrix encoder: launches the step units one at a time,
// round after round, hands the shared state buffer to the active unit and aborts hung units.
module round_scheduler #(
    parameter int NUM_UNITS  = 5,
    parameter int NUM_ROUNDS = 24,
    parameter int TIMEOUT    = 256,
    parameter int SELW       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [SELW-1:0]      mem_sel,
    output logic [2:0]           unit_idx,
    output logic [4:0]           round_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int              TW         = $clog2(TIMEOUT);
    localparam logic [2:0]      LAST_UNIT  = 3'(NUM_UNITS - 1);
    localparam logic [4:0]      LAST_ROUND = 5'(NUM_ROUNDS - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [SELW-1:0] HOST_SEL   = SELW'(NUM_UNITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_FINISH,
        S_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    unit_q, unit_d;
    logic [4:0]    round_q, round_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d = state_q;
        unit_d  = unit_q;
        round_d = round_q;
        timer_d = timer_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LAUNCH;
                    unit_d  = '0;
                    round_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion beats the watchdog when both happen in the same cycle.
                if (unit_done[unit_q]) begin
                    state_d = S_NEXT;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_ABORT;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (unit_q != LAST_UNIT) begin
                    unit_d  = unit_q + 1'b1;
                    state_d = S_LAUNCH;
                end else begin
                    unit_d = '0;
                    if (round_q == LAST_ROUND) begin
                        state_d = S_FINISH;
                    end else begin
                        round_d = round_q + 1'b1;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            unit_q  <= '0;
            round_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            round_q <= round_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode from registered state only, so they follow reset immediately.
    always_comb begin
        unit_start = '0;
        mem_sel    = HOST_SEL;
        if (state_q == S_LAUNCH) begin
            unit_start = NUM_UNITS'(1) << unit_q;
        end
        if (state_q == S_LAUNCH || state_q == S_WAIT || state_q == S_NEXT) begin
            mem_sel = SELW'(unit_q);
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH) || (state_q == S_ABORT);
    assign err       = err_q;
    assign unit_idx  = unit_q;
    assign round_idx = round_q;

endmodule

// File: tb/tb_round_scheduler.sv
// Self-checking bench for round_scheduler: each run's launch timeline is planned up front
// from random unit latencies, and the DUT is compared against it cycle by cycle.
module tb_round_scheduler;

    localparam int NU   = 5;
    localparam int NR   = 24;
    localparam int TO   = 256;
    localparam int SELW = 3;
    localparam int NL   = NU * NR;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NU-1:0]   unit_done;
    logic [NU-1:0]   unit_start;
    logic [SELW-1:0] mem_sel;
    logic [2:0]      unit_idx;
    logic [4:0]      round_idx;
    logic            busy;
    logic            done;
    logic            err;

    int checks   = 0;
    int errors   = 0;
    bit last_err = 1'b0;

    round_scheduler #(
        .NUM_UNITS (NU),
        .NUM_ROUNDS(NR),
        .TIMEOUT   (TO),
        .SELW      (SELW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .unit_done (unit_done),
        .unit_start(unit_start),
        .mem_sel   (mem_sel),
        .unit_idx  (unit_idx),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " unit_start"}, 32'(unit_start), 0);
        check({tag, " mem_sel"},    32'(mem_sel),    NU);
        check({tag, " unit_idx"},   32'(unit_idx),   0);
        check({tag, " round_idx"},  32'(round_idx),  0);
        check({tag, " busy"},       32'(busy),       0);
        check({tag, " done"},       32'(done),       0);
        check({tag, " err"},        32'(err),        0);
    endtask

    task automatic idle_checks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d busy", i),       32'(busy),       0);
            check($sformatf("idle%0d done", i),       32'(done),       0);
            check($sformatf("idle%0d mem_sel", i),    32'(mem_sel),    NU);
            check($sformatf("idle%0d unit_start", i), 32'(unit_start), 0);
            start     = 1'b0;
            unit_done = NU'($urandom);
        end
    endtask

    // One encode. Unit latency d (WAIT cycles up to and including the one seeing done) is drawn
    // per launch; d=0 marks a silent unit. Launch k happens at cycle L[k] (first LAUNCH = cycle 1),
    // L[k+1] = L[k] + 2 + d[k]; done lands at 1 + sum(2+d), or L[k]+1+TO for a silent unit.
    // rst_k >= 0 asserts async reset in the first WAIT cycle after that launch and abandons the run.
    task automatic run_encode(input int silent_k, input int max_d, input bit tied, input int rst_k);
        int d[NL];
        int lt[NL];
        int t, e, last_k, k, rst_at;
        bit ab;
        logic [NU-1:0] act, nz;

        ab     = 1'b0;
        last_k = NL - 1;
        t      = 1;
        for (int i = 0; i < NL; i++) begin
            d[i]  = tied ? 1 : int'($urandom_range(max_d, 1));
            if (i == silent_k) d[i] = 0;
            lt[i] = t;
            if (d[i] == 0) begin
                ab     = 1'b1;
                last_k = i;
                t      = t + 1 + TO;
                break;
            end
            t = t + 2 + d[i];
        end
        e      = t;
        rst_at = (rst_k >= 0) ? lt[rst_k] + 1 : -1;
        k      = 0;

        for (int c = 0; c <= e; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("start_idle busy", 32'(busy),    0);
                check("start_idle sel",  32'(mem_sel), NU);
                check("start_idle err",  32'(err),     32'(last_err));
                start     = 1'b1;
                unit_done = tied ? '1 : NU'($urandom);
                continue;
            end
            while (k < last_k && c >= lt[k+1]) k++;
            act = NU'(1) << (k % NU);

            check($sformatf("c%0d unit_start", c), 32'(unit_start), (c == lt[k]) ? 32'(act) : 0);
            check($sformatf("c%0d mem_sel", c),    32'(mem_sel),    (c == e) ? NU : k % NU);
            check($sformatf("c%0d busy", c),       32'(busy),       1);
            check($sformatf("c%0d done", c),       32'(done),       (c == e) ? 1 : 0);
            check($sformatf("c%0d err", c),        32'(err),        (c == e && ab) ? 1 : 0);
            if (c == lt[k] && c != e) begin
                check($sformatf("launch%0d unit_idx", k),  32'(unit_idx),  k % NU);
                check($sformatf("launch%0d round_idx", k), 32'(round_idx), k / NU);
            end
            if (c == e) begin
                check("end unit_idx",  32'(unit_idx),  ab ? last_k % NU : 0);
                check("end round_idx", 32'(round_idx), ab ? last_k / NU : NR - 1);
            end

            // Requests during a run must be ignored; done bits of other units are noise.
            start = 1'(($urandom) & 1);
            nz    = NU'($urandom);
            if (tied) begin
                nz = '1;
            end else if (c > lt[k] && (d[k] == 0 || c <= lt[k] + d[k])) begin
                nz[k % NU] = (d[k] != 0 && c == lt[k] + d[k]);
            end
            unit_done = nz;

            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1 check_reset_values("midrun_rst");
                @(posedge clk);
                @(negedge clk);
                rst       = 1'b0;
                start     = 1'b0;
                unit_done = '0;
                last_err  = 1'b0;
                return;
            end
        end
        last_err = ab;
        start    = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        unit_done = '0;
        #3 check_reset_values("por");
        @(negedge clk);
        rst = 1'b0;
        idle_checks(2);

        // Nominal: every unit answers in its first WAIT cycle -> done in cycle 361.
        run_encode(-1, 1, 1'b0, -1);
        idle_checks(2);

        // All done lines tied high: LAUNCH-cycle done ignored, still 3 cycles per unit.
        run_encode(-1, 1, 1'b1, -1);
        idle_checks(2);

        // Random latencies with foreign done noise.
        run_encode(-1, 4, 1'b0, -1);
        idle_checks(1);

        // Unit 1 hangs in round 3; the following run starts the cycle after done and clears err.
        run_encode(3 * NU + 1, 3, 1'b0, -1);
        run_encode(-1, 2, 1'b0, -1);
        idle_checks(1);

        // Async reset during WAIT of round 10 abandons the run without done; then a full run.
        run_encode(-1, 3, 1'b0, 10 * NU);
        idle_checks(3);
        run_encode(-1, 3, 1'b0, -1);
        idle_checks(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
